// File: rtl/alu_matrix_mac_seq_if.sv
// Handshake and operand/result bundle for the sequential NxN matrix MAC engine.
// The master side issues runs and reads results; the slave side is the engine.
interface alu_matrix_mac_seq_if #(
   parameter int N = 5,
   parameter int W = 8
);
   logic               start;
   logic               sat_mode;
   logic [N*N*W-1:0]   A_flat;
   logic [N*N*W-1:0]   B_flat;
   logic [N*N*W-1:0]   C_flat;
   logic               busy;
   logic               done;
   logic               overflow_flag;

   modport master (
      output start, sat_mode, A_flat, B_flat,
      input  C_flat, busy, done, overflow_flag
   );

   modport slave (
      input  start, sat_mode, A_flat, B_flat,
      output C_flat, busy, done, overflow_flag
   );
endinterface

// File: rtl/alu_matrix_mac_seq.sv
// Sequential signed NxN matrix multiplier C = A x B, one MAC per clock,
// i/j/k loop order, per-run wrap/saturate result mode and sticky overflow flag.
module alu_matrix_mac_seq #(
   parameter int N     = 5,
   parameter int W     = 8,
   parameter int ACC_W = 19
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_matrix_mac_seq_if.slave  bus
);
   localparam int            CW       = (N > 1) ? $clog2(N) : 1;
   localparam int            FW       = N * N * W;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;

   logic [FW-1:0]           r_a;
   logic [FW-1:0]           r_b;
   logic [FW-1:0]           r_c;
   logic                    r_sat;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_ovf;
   logic [CW-1:0]           r_i;
   logic [CW-1:0]           r_j;
   logic [CW-1:0]           r_k;
   logic signed [ACC_W-1:0] r_acc;

   logic                    w_last_k;
   logic                    w_last_j;
   logic                    w_last_mac;
   logic signed [W-1:0]     w_a_elem;
   logic signed [W-1:0]     w_b_elem;
   logic signed [2*W-1:0]   w_prod;
   logic signed [ACC_W-1:0] w_sum;

   // A sum fits in W signed bits only if all bits from W-1 upward agree.
   function automatic logic range_ovf(input logic signed [ACC_W-1:0] s);
      return !((&s[ACC_W-1:W-1]) || (~|s[ACC_W-1:W-1]));
   endfunction

   function automatic logic [W-1:0] shape_result(input logic signed [ACC_W-1:0] s,
                                                 input logic                    sat);
      logic [W-1:0] v;
      if (sat && range_ovf(s)) begin
         v = s[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         v = s[W-1:0];
      end
      return v;
   endfunction

   // Operand fetch, full-precision product and running sum for the current MAC.
   always_comb begin
      w_a_elem   = r_a[(int'(r_i) * N + int'(r_k)) * W +: W];
      w_b_elem   = r_b[(int'(r_k) * N + int'(r_j)) * W +: W];
      w_prod     = w_a_elem * w_b_elem;
      w_sum      = r_acc + $signed({{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod});
      w_last_k   = (r_k == LAST_IDX);
      w_last_j   = (r_j == LAST_IDX);
      w_last_mac = w_last_k && w_last_j && (r_i == LAST_IDX);
   end

   // Next-state decode for the IDLE/RUN controller.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next_state = S_RUN;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last_mac) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_RUN;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Operand latch, loop counters, accumulator and result/flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_c    <= '0;
         r_sat  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_ovf  <= 1'b0;
         r_i    <= '0;
         r_j    <= '0;
         r_k    <= '0;
         r_acc  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a    <= bus.A_flat;
                  r_b    <= bus.B_flat;
                  r_sat  <= bus.sat_mode;
                  r_c    <= '0;
                  r_ovf  <= 1'b0;
                  r_acc  <= '0;
                  r_i    <= '0;
                  r_j    <= '0;
                  r_k    <= '0;
                  r_busy <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_last_k) begin
                  r_c[(int'(r_i) * N + int'(r_j)) * W +: W] <= shape_result(w_sum, r_sat);
                  if (range_ovf(w_sum)) begin
                     r_ovf <= 1'b1;
                  end
                  r_acc <= '0;
                  r_k   <= '0;
                  if (w_last_j) begin
                     r_j <= '0;
                     r_i <= r_i + CW'(1);
                  end else begin
                     r_j <= r_j + CW'(1);
                  end
               end else begin
                  r_acc <= w_sum;
                  r_k   <= r_k + CW'(1);
               end
               // Final element: leave counters clean for the next run.
               if (w_last_mac) begin
                  r_i    <= '0;
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign bus.C_flat        = r_c;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.overflow_flag = r_ovf;

endmodule

// File: tb/tb_alu_matrix_mac_seq.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop and
// compare on every done pulse for a 5x5 and a 2x2 instance of the engine.
`timescale 1ns/1ps
module tb_alu_matrix_mac_seq;
   localparam int N   = 5;
   localparam int W   = 8;
   localparam int FW  = N * N * W;
   localparam int L   = N * N * N;
   localparam int N2  = 2;
   localparam int FW2 = N2 * N2 * W;
   localparam int L2  = N2 * N2 * N2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_matrix_mac_seq_if #(.N(N),  .W(W)) bus  ();
   alu_matrix_mac_seq_if #(.N(N2), .W(W)) bus2 ();

   alu_matrix_mac_seq #(.N(N),  .W(W), .ACC_W(19)) dut  (.clk(clk), .rst(rst), .bus(bus));
   alu_matrix_mac_seq #(.N(N2), .W(W), .ACC_W(17)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [FW-1:0] c;
      logic          ovf;
      int            dcyc;
      string         name;
   } exp_t;
   typedef struct {
      logic [FW2-1:0] c;
      logic           ovf;
      int             dcyc;
      string          name;
   } exp2_t;

   exp_t  q[$];
   exp2_t q2[$];
   exp_t  m_e;
   exp2_t m_e2;

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] fill(input logic [W-1:0] v);
      logic [FW-1:0] f;
      f = '0;
      for (int e = 0; e < N * N; e++) f[e*W +: W] = v;
      return f;
   endfunction

   function automatic logic [FW2-1:0] fill2(input logic [W-1:0] v);
      logic [FW2-1:0] f;
      f = '0;
      for (int e = 0; e < N2 * N2; e++) f[e*W +: W] = v;
      return f;
   endfunction

   function automatic logic [FW-1:0] ident();
      logic [FW-1:0] f;
      f = '0;
      for (int r = 0; r < N; r++) f[(r*N + r)*W +: W] = 8'h01;
      return f;
   endfunction

   // Monitor for the 5x5 engine.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected no pending run (cycle %0d)", cyc);
         end else begin
            m_e = q.pop_front();
            chk({m_e.name, "_C"}, bus.C_flat, m_e.c);
            chk_i({m_e.name, "_ovf"}, int'(bus.overflow_flag), int'(m_e.ovf));
            chk_i({m_e.name, "_done_cycle"}, cyc, m_e.dcyc);
         end
      end
   end

   // Monitor for the 2x2 engine.
   always @(negedge clk) begin
      if (bus2.done === 1'b1) begin
         if (q2.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done2: got done=1 expected no pending run (cycle %0d)", cyc);
         end else begin
            m_e2 = q2.pop_front();
            chk({m_e2.name, "_C"}, FW'(bus2.C_flat), FW'(m_e2.c));
            chk_i({m_e2.name, "_ovf"}, int'(bus2.overflow_flag), int'(m_e2.ovf));
            chk_i({m_e2.name, "_done_cycle"}, cyc, m_e2.dcyc);
         end
      end
   end

   task automatic run(input string name, input logic [FW-1:0] a, input logic [FW-1:0] b,
                      input logic sm, input logic [FW-1:0] ec, input logic eovf);
      @(negedge clk);
      bus.A_flat   = a;
      bus.B_flat   = b;
      bus.sat_mode = sm;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      q.push_back('{c: ec, ovf: eovf, dcyc: cyc + L, name: name});
   endtask

   task automatic run2(input string name, input logic [FW2-1:0] a, input logic [FW2-1:0] b,
                       input logic sm, input logic [FW2-1:0] ec, input logic eovf);
      @(negedge clk);
      bus2.A_flat   = a;
      bus2.B_flat   = b;
      bus2.sat_mode = sm;
      bus2.start    = 1'b1;
      @(posedge clk);
      #1;
      bus2.start = 1'b0;
      q2.push_back('{c: ec, ovf: eovf, dcyc: cyc + L2, name: name});
   endtask

   task automatic wait_idle(input string name);
      for (int t = 0; t < 600; t++) begin
         @(posedge clk);
         #2;
         if (q.size() == 0 && q2.size() == 0 && bus.busy === 1'b0 && bus2.busy === 1'b0) break;
      end
      chk_i({name, "_pending_after_wait"}, q.size() + q2.size(), 0);
   endtask

   logic [FW-1:0] bseq;
   int            bl;
   int            c0;

   initial begin
      bus.start  = 1'b0; bus.sat_mode  = 1'b0; bus.A_flat  = '0; bus.B_flat  = '0;
      bus2.start = 1'b0; bus2.sat_mode = 1'b0; bus2.A_flat = '0; bus2.B_flat = '0;
      bseq = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) bseq[(r*N + c)*W +: W] = 8'(r*5 + c - 12);

      repeat (3) @(posedge clk);
      #1;
      chk_i("rst_busy", int'(bus.busy), 0);
      chk_i("rst_done", int'(bus.done), 0);
      chk_i("rst_ovf", int'(bus.overflow_flag), 0);
      chk("rst_C", bus.C_flat, '0);
      @(negedge clk);
      rst = 1'b0;

      // Identity, also measuring how long busy stays high.
      run("identity", ident(), bseq, 1'b0, bseq, 1'b0);
      bl = 0;
      for (int t = 0; t < L + 5; t++) begin
         if (bus.busy === 1'b1) bl++;
         @(posedge clk);
         #1;
      end
      chk_i("identity_busy_cycles", bl, L);
      wait_idle("identity");

      run("wrap127", fill(8'h7F), fill(8'h7F), 1'b0, fill(8'h05), 1'b1);
      wait_idle("wrap127");
      run("sat127", fill(8'h7F), fill(8'h7F), 1'b1, fill(8'h7F), 1'b1);
      wait_idle("sat127");
      run("satneg", fill(8'h80), fill(8'h7F), 1'b1, fill(8'h80), 1'b1);
      wait_idle("satneg");
      run("minus1", fill(8'hFF), ident(), 1'b1, fill(8'hFF), 1'b0);
      wait_idle("minus1");

      run2("n2_sat", fill2(8'h80), fill2(8'h80), 1'b1, fill2(8'h7F), 1'b1);
      wait_idle("n2_sat");
      run2("n2_wrap", fill2(8'h80), fill2(8'h80), 1'b0, fill2(8'h00), 1'b1);
      wait_idle("n2_wrap");

      // Start and new operands mid-run must be ignored.
      run("ignore", fill(8'h01), fill(8'h02), 1'b0, fill(8'h0A), 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.A_flat = fill(8'h7F); bus.B_flat = fill(8'h7F); bus.sat_mode = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle("ignore");

      // Start held high through the done cycle launches a second run.
      @(negedge clk);
      bus.A_flat = ident(); bus.B_flat = fill(8'h03); bus.sat_mode = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      q.push_back('{c: fill(8'h03), ovf: 1'b0, dcyc: c0 + L, name: "held1"});
      q.push_back('{c: fill(8'h0A), ovf: 1'b0, dcyc: c0 + L + 1 + L, name: "held2"});
      bus.A_flat = fill(8'h01); bus.B_flat = fill(8'h02);
      while (cyc < c0 + L + 1) begin
         @(posedge clk);
         #1;
      end
      chk_i("held_busy_reasserted", int'(bus.busy), 1);
      chk_i("held_done_dropped", int'(bus.done), 0);
      chk("held_C_cleared", bus.C_flat, '0);
      bus.start = 1'b0;
      wait_idle("held");

      // Reset in the middle of a run aborts it without a done pulse.
      @(negedge clk);
      bus.A_flat = fill(8'h7F); bus.B_flat = fill(8'h7F); bus.sat_mode = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (59) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_i("midrst_busy", int'(bus.busy), 0);
      chk_i("midrst_done", int'(bus.done), 0);
      chk_i("midrst_ovf", int'(bus.overflow_flag), 0);
      chk("midrst_C", bus.C_flat, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (L + 10) @(posedge clk);
      run("after_rst", fill(8'h7F), fill(8'h7F), 1'b0, fill(8'h05), 1'b1);
      wait_idle("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
